ipm2t_hssthp_sig_sync_filt_v1_0: RTL and testbench
==================================================

Name: ipm2t_hssthp_sig_sync_filt_v1_0

Overview:
Multi-channel, parametrised successor to the 2-flop single-bit synchroniser used in the HSSTHP reset sequencer. Each channel has:
- a synchroniser chain of configurable depth;
- a per-bit reset value;
- a per-channel glitch filter, a persistence counter that ignores pulses shorter than FILT_LEN cycles;
- registered rise/fall strobes for the sequencer FSMs.

Typical use: PLL lock, signal-detect and CDR-lock status from the PMA into the clk domain.

Parameters:
CH_NUM, 4, number of independent channels (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (2..4)
RST_VAL, {CH_NUM{1'b0}}, per-bit reset value of sync chain and filtered output
FILT_LEN, 8, cycles the synced value must differ from current output before output updates (1..255)
CNT_W, $clog2(FILT_LEN+1), filter counter width (derived, not overridden)

Ports:
clk  input  1  destination-domain clock
rst_n  input  1  asynchronous, active-low reset
sig_async  input  CH_NUM  asynchronous input bits, one per channel
sig_synced  output  CH_NUM  synchronised and filtered level
sig_rise  output  CH_NUM  1-cycle strobe when sig_synced goes 0->1
sig_fall  output  CH_NUM  1-cycle strobe when sig_synced goes 1->0
filt_busy  output  CH_NUM  channel counter non-zero: a change is pending

Behaviour:
- Reset values (rst_n low, asynchronous):
  - every flop of channel i's chain = RST_VAL[i];
  - sig_synced[i] = RST_VAL[i];
  - filter counter = 0;
  - sig_rise, sig_fall, filt_busy = 0.
- Reset release is synchronous to the next clk edge. There is no internal reset synchroniser; rst_n is supplied already synchronised.
- Sync chain per channel: s[0] <= sig_async[i]; s[k] <= s[k-1]. The last stage, s_last, feeds the filter. No logic between stages.
- Filter, per channel, each clk edge:
  - if s_last == sig_synced[i]: cnt <= 0.
  - else if cnt == FILT_LEN-1: sig_synced[i] <= s_last; cnt <= 0.
  - else: cnt <= cnt + 1.
- Filter consequences:
  - an input held stable for >= SYNC_STAGES+FILT_LEN cycles propagates;
  - a glitch visible at s_last for fewer than FILT_LEN consecutive cycles is discarded and the counter restarts from 0;
  - with FILT_LEN=1, the filter is a single extra register.
- Latency: a sig_async change sampled at edge 0 is seen at s_last after SYNC_STAGES edges. sig_synced updates FILT_LEN edges after that, for a total of SYNC_STAGES+FILT_LEN edges.
- Strobes are registered in the same edge that updates sig_synced:
  - sig_rise[i] = 1 for exactly one cycle when sig_synced[i] transitions 0->1;
  - sig_fall[i] likewise for 1->0;
  - rise and fall are never asserted together on one channel.
- filt_busy[i] = (cnt != 0), registered as the counter is.
- Counter never wraps: its maximum value is FILT_LEN-1, so CNT_W always suffices.
- Simultaneous events: channels are fully independent, and any number may update or strobe in the same cycle.
- Reset mid-operation: sig_synced returns to RST_VAL immediately. A pending count is discarded. No strobe is generated by reset assertion or release.
- Post-reset input differing from RST_VAL: treated as a normal change. It produces one strobe after the full latency.
- Parameter checks: an elaboration-time error is raised if SYNC_STAGES<2, FILT_LEN<1 or CH_NUM<1.

Test Plan:
- Reset value: CH_NUM=4, RST_VAL=4'b1010, sig_async=4'b0000. During reset and release, check sig_synced=4'b1010 and all strobes 0. With the defaults (SYNC_STAGES=2, FILT_LEN=8), ch1 and ch3 go to 0 at release+10 edges with one sig_fall pulse each.
- Latency: defaults, RST_VAL=0. Raise sig_async[0] at edge 0 and hold. sig_synced[0]=1 and sig_rise[0]=1 are seen after edge 10 and remain 0 before. sig_rise[0] is 0 at edge 11.
- Glitch rejection: FILT_LEN=8. Pulse sig_async[2] high for 7 cycles, then low. sig_synced[2] stays 0 and no strobe occurs. filt_busy[2] is high for 7 cycles, then the counter returns to 0.
- Glitch restart: high 5 cycles, low 1, high 8+. The output rises only 8 cycles after the second rising edge reaches s_last, not after cumulative time.
- Multi-channel simultaneity: toggle all 4 channels together 0->1, then 1->0 after 20 cycles. All sig_rise bits pulse on the same edge, then all sig_fall bits pulse together. There is no cross-channel interaction.
- Reset mid-count: start a 0->1 change, then assert rst_n at cnt=4. Outputs return to RST_VAL, filt_busy=0, and no strobe occurs. After release with the input still high, a full SYNC_STAGES+FILT_LEN latency elapses before sig_rise.

Source files
------------

// File: rtl/ipm2t_hssthp_sig_sync_filt_v1_0.sv
// ----------------------------------------------------------------------------
// ipm2t_hssthp_sig_sync_filt_v1_0
// Multi-channel level synchroniser with a persistence (glitch) filter and
// registered edge strobes. Each channel carries a PMA status bit (PLL lock,
// signal detect, CDR lock) into the clk domain.
//
// Ports:
//   clk         destination-domain clock
//   rst_n       asynchronous active-low reset (already synchronised upstream)
//   sig_async   [CH_NUM] asynchronous status inputs
//   sig_synced  [CH_NUM] synchronised, filtered level
//   sig_rise    [CH_NUM] one-cycle strobe on sig_synced 0->1
//   sig_fall    [CH_NUM] one-cycle strobe on sig_synced 1->0
//   filt_busy   [CH_NUM] filter counter non-zero (change pending)
// ----------------------------------------------------------------------------
module ipm2t_hssthp_sig_sync_filt_v1_0 #(
    parameter int unsigned       CH_NUM      = 4,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [CH_NUM-1:0] RST_VAL     = '0,
    parameter int unsigned       FILT_LEN    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] sig_async,
    output logic [CH_NUM-1:0] sig_synced,
    output logic [CH_NUM-1:0] sig_rise,
    output logic [CH_NUM-1:0] sig_fall,
    output logic [CH_NUM-1:0] filt_busy
);

    localparam int unsigned      CNT_W   = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

    // Elaboration-time parameter range checks
    if (SYNC_STAGES < 2) begin : g_err_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (FILT_LEN < 1) begin : g_err_filt
        $error("FILT_LEN must be >= 1");
    end
    if (CH_NUM < 1) begin : g_err_ch
        $error("CH_NUM must be >= 1");
    end

    for (genvar i = 0; i < int'(CH_NUM); i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   synced_q;
        logic                   synced_d;
        logic                   rise_q;
        logic                   rise_d;
        logic                   fall_q;
        logic                   fall_d;
        logic                   busy_q;
        logic                   s_last;

        assign s_last = sync_q[SYNC_STAGES-1];

        // Plain shift-register synchroniser, no logic between stages
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= {SYNC_STAGES{RST_VAL[i]}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sig_async[i]};
            end
        end

        // Persistence filter: output follows s_last only after FILT_LEN
        // consecutive differing samples; any agreement restarts the count.
        always_comb begin
            cnt_d    = cnt_q;
            synced_d = synced_q;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            if (s_last == synced_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_d    = '0;
                synced_d = s_last;
                rise_d   = s_last;
                fall_d   = ~s_last;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q    <= '0;
                synced_q <= RST_VAL[i];
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                synced_q <= synced_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                busy_q   <= (cnt_d != '0);
            end
        end

        assign sig_synced[i] = synced_q;
        assign sig_rise[i]   = rise_q;
        assign sig_fall[i]   = fall_q;
        assign filt_busy[i]  = busy_q;
    end

endmodule

// File: tb/tb_ipm2t_hssthp_sig_sync_filt_v1_0.sv
// ----------------------------------------------------------------------------
// Bench for ipm2t_hssthp_sig_sync_filt_v1_0.
// Main DUT: CH_NUM=4, SYNC_STAGES=2, FILT_LEN=8, RST_VAL=4'b1010.
// Boundary DUT: CH_NUM=1, SYNC_STAGES=3, FILT_LEN=1, RST_VAL=0.
// Expected outputs are pushed to a queue before each clock edge and popped
// and compared #1 after it.
// ----------------------------------------------------------------------------
module tb_ipm2t_hssthp_sig_sync_filt_v1_0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sig_async;
    logic [3:0] sig_synced;
    logic [3:0] sig_rise;
    logic [3:0] sig_fall;
    logic [3:0] filt_busy;
    logic [0:0] b_async;
    logic [0:0] b_synced;
    logic [0:0] b_rise;
    logic [0:0] b_fall;
    logic [0:0] b_busy;

    always #5 clk = ~clk;

    ipm2t_hssthp_sig_sync_filt_v1_0 #(
        .CH_NUM      (4),
        .SYNC_STAGES (2),
        .RST_VAL     (4'b1010),
        .FILT_LEN    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_async  (sig_async),
        .sig_synced (sig_synced),
        .sig_rise   (sig_rise),
        .sig_fall   (sig_fall),
        .filt_busy  (filt_busy)
    );

    ipm2t_hssthp_sig_sync_filt_v1_0 #(
        .CH_NUM      (1),
        .SYNC_STAGES (3),
        .RST_VAL     (1'b0),
        .FILT_LEN    (1)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_async  (b_async),
        .sig_synced (b_synced),
        .sig_rise   (b_rise),
        .sig_fall   (b_fall),
        .filt_busy  (b_busy)
    );

    typedef struct {
        string      tag;
        logic [3:0] s;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] b;
        logic       bs;
        logic       br;
        logic       bf;
        logic       bb;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [3:0] s, input logic [3:0] r,
                        input logic [3:0] f, input logic [3:0] b,
                        input logic bs, input logic br, input logic bf, input logic bb);
        exp_t e;
        e.tag = tag;
        e.s = s; e.r = r; e.f = f; e.b = b;
        e.bs = bs; e.br = br; e.bf = bf; e.bb = bb;
        sb_q.push_back(e);
    endtask

    task automatic cmp(input string tag, input string what,
                       input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, what, got, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected>0 entries");
            return;
        end
        e = sb_q.pop_front();
        cmp(e.tag, "sig_synced", sig_synced, e.s);
        cmp(e.tag, "sig_rise",   sig_rise,   e.r);
        cmp(e.tag, "sig_fall",   sig_fall,   e.f);
        cmp(e.tag, "filt_busy",  filt_busy,  e.b);
        cmp(e.tag, "b_synced",   {3'b000, b_synced}, {3'b000, e.bs});
        cmp(e.tag, "b_rise",     {3'b000, b_rise},   {3'b000, e.br});
        cmp(e.tag, "b_fall",     {3'b000, b_fall},   {3'b000, e.bf});
        cmp(e.tag, "b_busy",     {3'b000, b_busy},   {3'b000, e.bb});
    endtask

    // One clock: queue expectation, advance past the edge, compare
    task automatic cyc(input string tag, input logic [3:0] s, input logic [3:0] r,
                       input logic [3:0] f, input logic [3:0] b,
                       input logic bs, input logic br, input logic bf, input logic bb);
        push(tag, s, r, f, b, bs, br, bf, bb);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Held level change on the main DUT, starting from a settled old_v.
    // Sampled at edge 1, visible at s_last after edge 2, counter 1..7 on
    // edges 3..9, output and strobe on edge 10 (SYNC_STAGES+FILT_LEN).
    task automatic run_change(input string tag, input logic [3:0] old_v,
                              input logic [3:0] new_v, input int ncyc);
        logic [3:0] chg;
        chg = old_v ^ new_v;
        sig_async = new_v;
        for (int n = 1; n <= ncyc; n++) begin
            cyc(tag,
                (n >= 10) ? new_v : old_v,
                (n == 10) ? (chg & new_v) : 4'b0000,
                (n == 10) ? (chg & ~new_v) : 4'b0000,
                (n >= 3 && n <= 9) ? chg : 4'b0000,
                1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sig_async = 4'b0000;
        b_async   = 1'b0;

        // Reset value held while rst_n low
        for (int n = 0; n < 3; n++) begin
            cyc("rst_hold", 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Release with input 0: ch1/ch3 fall after the full latency
        rst_n = 1'b1;
        run_change("rst_rel", 4'b1010, 4'b0000, 14);

        // Single-channel latency, both directions
        run_change("lat_up", 4'b0000, 4'b0001, 12);
        run_change("lat_dn", 4'b0001, 4'b0000, 12);

        // All channels together
        run_change("multi_up", 4'b0000, 4'b1111, 20);
        run_change("multi_dn", 4'b1111, 4'b0000, 20);

        // 7-cycle pulse on ch2 is rejected
        for (int n = 1; n <= 14; n++) begin
            sig_async = (n <= 7) ? 4'b0100 : 4'b0000;
            cyc("glitch_rej", 4'b0000, 4'b0000, 4'b0000,
                (n >= 3 && n <= 9) ? 4'b0100 : 4'b0000,
                1'b0, 1'b0, 1'b0, 1'b0);
        end

        // High 5, low 1, then high: count restarts, rise at edge 16
        for (int n = 1; n <= 18; n++) begin
            sig_async = (n == 6) ? 4'b0000 : 4'b0100;
            cyc("glitch_rst",
                (n >= 16) ? 4'b0100 : 4'b0000,
                (n == 16) ? 4'b0100 : 4'b0000,
                4'b0000,
                ((n >= 3 && n <= 7) || (n >= 9 && n <= 15)) ? 4'b0100 : 4'b0000,
                1'b0, 1'b0, 1'b0, 1'b0);
        end
        run_change("glitch_dn", 4'b0100, 4'b0000, 12);

        // Reset asserted with ch0 count at 4
        sig_async = 4'b0001;
        for (int n = 1; n <= 6; n++) begin
            cyc("mid_cnt", 4'b0000, 4'b0000, 4'b0000,
                (n >= 3) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        push("mid_rst_async", 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_out();
        for (int n = 0; n < 2; n++) begin
            cyc("mid_rst_hold", 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        run_change("mid_rel", 4'b1010, 4'b0001, 14);
        run_change("mid_dn", 4'b0001, 4'b0000, 12);

        // FILT_LEN=1, SYNC_STAGES=3: latency 4 edges, busy never set
        b_async = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            cyc("b_up", 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                (n >= 4), (n == 4), 1'b0, 1'b0);
        end
        b_async = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            cyc("b_dn", 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                (n < 4), 1'b0, (n == 4), 1'b0);
        end
        // Single-cycle pulse passes straight through a length-1 filter
        for (int n = 1; n <= 7; n++) begin
            b_async = (n == 1);
            cyc("b_pulse", 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                (n == 4), (n == 4), (n == 5), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
